// File: rtl/pe_sequencer_if.sv
// pe_sequencer_if: bundles the config port, run handshake, ALU instruction
// interface and result port of one PE sequencer.
// Optional macro PE_SEQ_CYCLE_COUNT_EN adds the run_cycles counter signal.
//
// Result handshake: out_valid/out_data are driven by the sequencer and stay
// stable from the cycle out_valid rises until the clock edge on which
// out_ready is high; that edge completes the transfer. out_ready has no effect
// while out_valid is low.
interface pe_sequencer_if #(
    parameter int AW = 4
);
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [31:0]   cfg_wdata;
    logic          start;
    logic [31:0]   in_data;
    logic          busy;
    logic          alu_en;
    logic [3:0]    alu_instr;
    logic [31:0]   alu_in1;
    logic [31:0]   alu_in2;
    logic [31:0]   alu_out;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    // FSM state for observation: 0 IDLE, 1 FETCH, 2 EXEC, 3 OUT
    logic [1:0]    fsm_state;
`ifdef PE_SEQ_CYCLE_COUNT_EN
    logic [15:0]   run_cycles;
`endif

    // host / environment side: drives config, start, ALU result and out_ready
    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, in_data, alu_out, out_ready,
        input  busy, alu_en, alu_instr, alu_in1, alu_in2, out_valid, out_data,
               fsm_state
`ifdef PE_SEQ_CYCLE_COUNT_EN
        , input run_cycles
`endif
    );

    // sequencer side
    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, in_data, alu_out, out_ready,
        output busy, alu_en, alu_instr, alu_in1, alu_in2, out_valid, out_data,
               fsm_state
`ifdef PE_SEQ_CYCLE_COUNT_EN
        , output run_cycles
`endif
    );
endinterface

// File: rtl/pe_sequencer.sv
// pe_sequencer: per-PE instruction sequencer for a CGRA tile.
// Holds a DEPTH-entry program memory loaded while idle, runs it after start
// (two cycles per instruction: FETCH then EXEC), drives the PE ALU
// combinationally during EXEC, writes ALU results into r0..r3 and returns one
// 32-bit result per run over out_valid/out_ready.
// Optional macro PE_SEQ_CYCLE_COUNT_EN adds the saturating run_cycles counter.
module pe_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input logic           clk,
    input logic           rst,
    pe_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] pc;
    logic [31:0]   ir;
    logic [31:0]   regs [4];
    logic [31:0]   mem  [DEPTH];
    logic          out_valid_q;
    logic [31:0]   out_data_q;

    // decoded fields of the instruction being executed
    logic [1:0]  dst;
    logic [1:0]  src1;
    logic [1:0]  src2;
    logic        imm_sel;
    logic [3:0]  opcode;
    logic [31:0] imm;
    logic        is_alu;
    logic        is_halt;
    logic        last_slot;
    logic        in_exec;
    logic        accept_start;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        unused_ir_bits;

    assign dst      = ir[29:28];
    assign src1     = ir[27:26];
    assign src2     = ir[25:24];
    assign imm_sel  = ir[23];
    assign opcode   = ir[18:15];
    assign imm      = {17'd0, ir[14:0]};
    assign unused_ir_bits = ^{ir[31:30], ir[22:19]};

    // opcodes 0xxx go to the ALU; 1111 halts; 1000..1110 are NOPs
    assign is_alu   = ~opcode[3];
    assign is_halt  = (opcode == 4'hF);
    // the last slot ends the run after executing, so pc never wraps
    assign last_slot = (pc == AW'(DEPTH - 1));
    assign in_exec   = (state == EXEC);
    assign accept_start = (state == IDLE) && bus.start;

    // operands read the register values from before this EXEC's writeback
    assign operand1 = regs[src1];
    assign operand2 = imm_sel ? imm : regs[src2];

    // program memory: written only while idle, not reset so it survives rst
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.cfg_we) begin
            mem[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    // register file: r0 loaded on accepted start, ALU results written at end of EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (accept_start) begin
            regs[0] <= bus.in_data;
        end else if (in_exec && is_alu) begin
            regs[dst] <= bus.alu_out;
        end
    end

    // sequencing FSM: fetch/execute loop and result hold until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pc    <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    ir    <= mem[pc];
                    state <= EXEC;
                end
                EXEC: begin
                    if (is_halt) begin
                        out_data_q  <= regs[dst];
                        out_valid_q <= 1'b1;
                        state       <= OUT;
                    end else if (last_slot) begin
                        // implicit halt: report r[dst] including this slot's writeback
                        out_data_q  <= is_alu ? bus.alu_out : regs[dst];
                        out_valid_q <= 1'b1;
                        state       <= OUT;
                    end else begin
                        pc    <= pc + AW'(1);
                        state <= FETCH;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ALU drive: live only during EXEC, all zero otherwise
    always_comb begin
        bus.alu_en    = 1'b0;
        bus.alu_instr = '0;
        bus.alu_in1   = '0;
        bus.alu_in2   = '0;
        if (in_exec) begin
            bus.alu_en    = is_alu;
            bus.alu_instr = opcode;
            bus.alu_in1   = operand1;
            bus.alu_in2   = operand2;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.fsm_state = state;

`ifdef PE_SEQ_CYCLE_COUNT_EN
    logic [15:0] cycle_cnt;

    // run length: cleared on accepted start, counts FETCH/EXEC cycles, saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (accept_start) begin
            cycle_cnt <= '0;
        end else if ((state == FETCH || state == EXEC) && cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    assign bus.run_cycles = cycle_cnt;
`endif
endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: directed bench for pe_sequencer with a behavioural ALU.
// Table of whole runs plus hand-written sequences for EXEC drive, backpressure,
// mid-run reset, register persistence, config lockout and cfg/start collision.
module tb_pe_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pe_sequencer_if #(.AW(4)) bus ();

    pe_sequencer #(.DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // behavioural ALU: 0 add, 1 sub, 2 and, 3 shl, 4 or, 5 ult, 6 xor, 7 pass in2
    function automatic logic [31:0] alu_model(input logic en, input logic [3:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        if (!en) return 32'd0;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a << b[4:0];
            4'd4:    return a | b;
            4'd5:    return {31'd0, (a < b)};
            4'd6:    return a ^ b;
            4'd7:    return b;
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_out = alu_model(bus.alu_en, bus.alu_instr, bus.alu_in1, bus.alu_in2);

    function automatic logic [31:0] mk(input logic [1:0] dst, input logic [1:0] s1,
                                       input logic [1:0] s2, input logic isel,
                                       input logic [3:0] op, input logic [14:0] imm);
        return {2'b00, dst, s1, s2, isel, 4'b0000, op, imm};
    endfunction

    localparam int P_BASIC = 0;
    localparam int P_CMP   = 1;
    localparam int P_IMPL  = 2;

    typedef struct {
        string       name;
        int          prog;
        logic [31:0] in_data;
        logic        ready_early;
        logic [31:0] exp_out;
        int          exp_edges;
    } vec_t;

    vec_t vecs[6];
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    function automatic vec_t mkv(input string n, input int p, input logic [31:0] d,
                                 input logic re, input logic [31:0] e, input int ed);
        vec_t v;
        v.name = n; v.prog = p; v.in_data = d; v.ready_early = re;
        v.exp_out = e; v.exp_edges = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // driver: one config write, one cycle long
    task automatic write_slot(input logic [3:0] a, input logic [31:0] w);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = w;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic load_prog(input int p);
        case (p)
            P_BASIC: begin
                write_slot(4'd0, mk(2'd1, 2'd0, 2'd0, 1'b1, 4'h0, 15'd5));
                write_slot(4'd1, mk(2'd2, 2'd1, 2'd0, 1'b1, 4'h3, 15'd2));
                write_slot(4'd2, mk(2'd2, 2'd0, 2'd0, 1'b0, 4'hF, 15'd0));
            end
            P_CMP: begin
                write_slot(4'd0, mk(2'd1, 2'd0, 2'd0, 1'b1, 4'h7, 15'd7));
                write_slot(4'd1, mk(2'd0, 2'd0, 2'd0, 1'b0, 4'hA, 15'd0));
                write_slot(4'd2, mk(2'd2, 2'd0, 2'd1, 1'b0, 4'h5, 15'd0));
                write_slot(4'd3, mk(2'd2, 2'd0, 2'd0, 1'b0, 4'hF, 15'd0));
            end
            default: begin
                for (int s = 0; s < 16; s++) begin
                    write_slot(4'(s), mk(2'd0, 2'd0, 2'd0, 1'b1, 4'h0, 15'd1));
                end
            end
        endcase
    endtask

    // driver + monitor: full run with latency, result and return-to-idle checks
    task automatic run(input string name, input logic [31:0] din, input logic [31:0] exp_out,
                       input int exp_edges, input logic ready_early);
        int edges;
        logic [31:0] exp;
        exp_q.push_back(exp_out);
        bus.in_data = din; bus.start = 1'b1; bus.out_ready = ready_early;
        @(negedge clk);
        bus.start = 1'b0;
        edges = 1;
        while (!bus.out_valid && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check({name, "_lat"}, 32'(edges), 32'(exp_edges));
        exp = exp_q.pop_front();
        check({name, "_data"}, bus.out_data, exp);
`ifdef PE_SEQ_CYCLE_COUNT_EN
        check({name, "_cycles"}, {16'd0, bus.run_cycles}, 32'(exp_edges - 1));
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    // bounded wait for a result already in flight, then accept it
    task automatic finish_run(input string name, input logic [31:0] exp_out);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({name, "_data"}, bus.out_data, exp_out);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.start = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

        vecs[0] = mkv("basic_3",  P_BASIC, 32'd3,  1'b0, 32'd32, 7);
        vecs[1] = mkv("basic_10", P_BASIC, 32'd10, 1'b1, 32'd60, 7);
        vecs[2] = mkv("cmp_4",    P_CMP,   32'd4,  1'b0, 32'd1,  9);
        vecs[3] = mkv("cmp_9",    P_CMP,   32'd9,  1'b0, 32'd0,  9);
        vecs[4] = mkv("impl_0",   P_IMPL,  32'd0,  1'b0, 32'd16, 33);
        vecs[5] = mkv("impl_5",   P_IMPL,  32'd5,  1'b1, 32'd21, 33);

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy",      {31'd0, bus.busy},      32'd0);
        check("rst_alu_en",    {31'd0, bus.alu_en},    32'd0);
        check("rst_alu_instr", {28'd0, bus.alu_instr}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data",  bus.out_data,           32'd0);
        check("rst_state",     {30'd0, bus.fsm_state}, 32'd0);
`ifdef PE_SEQ_CYCLE_COUNT_EN
        check("rst_cycles",    {16'd0, bus.run_cycles}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // table of whole runs
        for (int i = 0; i < 6; i++) begin
            load_prog(vecs[i].prog);
            run(vecs[i].name, vecs[i].in_data, vecs[i].exp_out, vecs[i].exp_edges,
                vecs[i].ready_early);
        end

        // ALU drive per state, including the NOP EXEC cycle
        load_prog(P_CMP);
        bus.in_data = 32'd4; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("fetch_state",   {30'd0, bus.fsm_state}, 32'd1);
        check("fetch_alu_en",  {31'd0, bus.alu_en},    32'd0);
        check("fetch_in1",     bus.alu_in1,            32'd0);
        check("fetch_instr",   {28'd0, bus.alu_instr}, 32'd0);
        @(negedge clk);
        check("exec0_alu_en",  {31'd0, bus.alu_en},    32'd1);
        check("exec0_instr",   {28'd0, bus.alu_instr}, 32'd7);
        check("exec0_in2",     bus.alu_in2,            32'd7);
        check("exec0_in1",     bus.alu_in1,            32'd4);
        repeat (2) @(negedge clk);
        check("nop_state",     {30'd0, bus.fsm_state}, 32'd2);
        check("nop_alu_en",    {31'd0, bus.alu_en},    32'd0);
        check("nop_instr",     {28'd0, bus.alu_instr}, 32'd10);
        finish_run("nop_run", 32'd1);

        // backpressure: result held, start ignored while waiting
        load_prog(P_BASIC);
        bus.in_data = 32'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n < 20 && !bus.out_valid; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                bus.start = 1'b1; bus.in_data = 32'd99;
            end
            @(negedge clk);
            bus.start = 1'b0;
            check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_data",  bus.out_data,           32'd32);
            check("bp_busy",  {31'd0, bus.busy},      32'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_state_idle", {30'd0, bus.fsm_state}, 32'd0);
        check("bp_valid_low",  {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("bp_no_restart", {31'd0, bus.busy},      32'd0);
        run("bp_rerun", 32'd3, 32'd32, 7, 1'b0);

        // reset during EXEC of slot1
        bus.in_data = 32'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_exec1_instr", {28'd0, bus.alu_instr}, 32'd3);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy",   {31'd0, bus.busy},      32'd0);
        check("mid_rst_alu_en", {31'd0, bus.alu_en},    32'd0);
        check("mid_rst_in1",    bus.alu_in1,            32'd0);
        check("mid_rst_state",  {30'd0, bus.fsm_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("rst_rerun", 32'd3, 32'd32, 7, 1'b0);

        // r2 persists across runs; a reset clears it but keeps the program
        write_slot(4'd0, mk(2'd2, 2'd0, 2'd0, 1'b0, 4'hF, 15'd0));
        run("persist_r2", 32'd7, 32'd32, 3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run("cleared_r2", 32'd7, 32'd0, 3, 1'b0);

        // cfg write and start in the same IDLE cycle: run sees the new slot0
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0;
        bus.cfg_wdata = mk(2'd0, 2'd0, 2'd0, 1'b0, 4'hF, 15'd0);
        run("collide", 32'd11, 32'd11, 3, 1'b0);
        bus.cfg_we = 1'b0;

        // config writes while busy are dropped
        load_prog(P_BASIC);
        bus.in_data = 32'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0;
        bus.cfg_wdata = mk(2'd0, 2'd0, 2'd0, 1'b0, 4'hF, 15'd0);
        repeat (3) @(negedge clk);
        bus.cfg_we = 1'b0;
        finish_run("lock_run", 32'd32);
        run("lock_rerun", 32'd3, 32'd32, 7, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
